mux_scan_ctrl: RTL and testbench

//   Upstream controller for the 4:1 mux (mux4to1). Drives select lines S0/S1 to step through

---
 rtl/mux_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
`timescale 1ns/1ps
// mux_scan_ctrl
// Upstream scan controller for a 4:1 mux. It walks the select lines through
// channels 0..3 and holds each channel for DWELL cycles so the mux output can
// settle. It captures Y at the end of each dwell and publishes the four bits
// as one word with a single-cycle valid strobe.
//
// Optional feature macro: AUTO_RESCAN_EN
//   defined   - DONE goes straight back to SCAN, so scanning is continuous
//               after the first start and only rst stops it.
//   undefined - DONE returns to IDLE, and every scan needs a new start.
//
// Channel index is {S0,S1}: S0 is the select MSB and S1 is the LSB.
// DWELL legal range is 1..255.

module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       S0,
  output logic       S1,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  // The counter only needs to reach DWELL-1, because it clears on the capture edge.
  localparam int            CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ch;
  logic [2:0]    r_shadow;
  logic [3:0]    r_sample;
  logic          r_valid;

  logic w_scanning;
  logic w_capture;
  logic w_lastCh;

  assign w_scanning = (r_state == ST_SCAN);
  assign w_capture  = w_scanning && (r_cnt == CNT_LAST);
  assign w_lastCh   = (r_ch == 2'd3);

  // Sequence through IDLE -> SCAN -> DONE.
  // Each channel is held for DWELL cycles. r_ch is kept at zero outside SCAN,
  // so the select outputs read 00 in IDLE and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ch    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_cnt   <= '0;
            r_ch    <= 2'd0;
          end
        end
        ST_SCAN: begin
          if (w_capture) begin
            r_cnt <= '0;
            if (w_lastCh) begin
              r_ch    <= 2'd0;
              r_state <= ST_DONE;
            end else begin
              r_ch <= r_ch + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
`ifdef AUTO_RESCAN_EN
          r_state <= ST_SCAN;
          r_cnt   <= '0;
          r_ch    <= 2'd0;
`else
          r_state <= ST_IDLE;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_ch    <= 2'd0;
        end
      endcase
    end
  end

  // Capture Y into the shadow register for channels 0..2.
  // On the channel 3 capture, publish the whole word and raise valid for one cycle.
  // The published word is updated only at the end of a complete scan, so a
  // partial scan never disturbs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= 3'b000;
      r_sample <= 4'b0000;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_capture) begin
        case (r_ch)
          2'd0: r_shadow[0] <= y_in;
          2'd1: r_shadow[1] <= y_in;
          2'd2: r_shadow[2] <= y_in;
          default: begin
            r_sample <= {y_in, r_shadow};
            r_valid  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Select lines come straight from the channel register.
  // They therefore change only on a capture edge or a state change.
  assign S0     = r_ch[1];
  assign S1     = r_ch[0];
  assign sample = r_sample;
  assign valid  = r_valid;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
`timescale 1ns/1ps
// tb_mux_scan_ctrl
// Directed bench for mux_scan_ctrl. It instantiates three controllers with
// DWELL = 4, 1 and 2. Each controller closes the loop through its own 4:1
// mux model, driven from the shared muxIn vector (bit n is mux input In).
// When AUTO_RESCAN_EN is defined, only the reset and continuous-rescan
// scenarios are run.

module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] startVec;
  logic [3:0] muxIn;

  wire  [2:0] s0Vec;
  wire  [2:0] s1Vec;
  wire  [2:0] validVec;
  wire  [2:0] busyVec;
  wire  [2:0] yVec;
  wire  [3:0] sample0;
  wire  [3:0] sample1;
  wire  [3:0] sample2;

  int vectorCount;
  int missCount;

  // Free-running clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mux models: each controller sees the input its own select lines pick
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : gMux
    assign yVec[gi] = muxIn[{s0Vec[gi], s1Vec[gi]}];
  end

  mux_scan_ctrl #(.DWELL(4)) dut4 (
    .clk(clk), .rst(rst), .start(startVec[0]), .y_in(yVec[0]),
    .S0(s0Vec[0]), .S1(s1Vec[0]), .sample(sample0),
    .valid(validVec[0]), .busy(busyVec[0])
  );

  mux_scan_ctrl #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(startVec[1]), .y_in(yVec[1]),
    .S0(s0Vec[1]), .S1(s1Vec[1]), .sample(sample1),
    .valid(validVec[1]), .busy(busyVec[1])
  );

  mux_scan_ctrl #(.DWELL(2)) dut2 (
    .clk(clk), .rst(rst), .start(startVec[2]), .y_in(yVec[2]),
    .S0(s0Vec[2]), .S1(s1Vec[2]), .sample(sample2),
    .valid(validVec[2]), .busy(busyVec[2])
  );

  function automatic logic [3:0] sampleOf(input int id);
    case (id)
      0:       return sample0;
      1:       return sample1;
      default: return sample2;
    endcase
  endfunction

  function automatic logic [3:0] ctrlOf(input int id);
    return {s0Vec[id], s1Vec[id], busyVec[id], validVec[id]};
  endfunction

  // Assert reset between clock edges and check every output clears at once.
  task automatic test_reset();
    rst      = 1'b0;
    startVec = 3'b000;
    muxIn    = 4'b0000;
    #2 rst = 1'b1;
    #1;
    for (int id = 0; id < 3; id++) begin
      vectorCount++;
      if (ctrlOf(id) !== 4'b0000) begin
        missCount++;
        $display("[TB] FAIL reset_ctrl dut%0d {sel,busy,valid}: got %b want %b", id, ctrlOf(id), 4'b0000);
      end
      vectorCount++;
      if (sampleOf(id) !== 4'b0000) begin
        missCount++;
        $display("[TB] FAIL reset_sample dut%0d: got %b want %b", id, sampleOf(id), 4'b0000);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One full scan from IDLE, checked every cycle.
  // The task is entered and left 1 time unit after a rising edge.
  task automatic run_scan(input int id, input int dw, input logic [3:0] ins,
                          input logic [3:0] expSample, input logic [3:0] prevSample,
                          input int pulseAt, input int postCycles, input string tag);
    logic [3:0] want;
    muxIn        = ins;
    startVec[id] = 1'b1;
    @(posedge clk); #1;
    startVec[id] = 1'b0;
    for (int c = 0; c < 4 * dw; c++) begin
      want = {2'(c / dw), 2'b10};
      vectorCount++;
      if (ctrlOf(id) !== want) begin
        missCount++;
        $display("[TB] FAIL %s scan c=%0d {sel,busy,valid}: got %b want %b", tag, c, ctrlOf(id), want);
      end
      vectorCount++;
      if (sampleOf(id) !== prevSample) begin
        missCount++;
        $display("[TB] FAIL %s sample_hold c=%0d: got %b want %b", tag, c, sampleOf(id), prevSample);
      end
      startVec[id] = (c == pulseAt);
      @(posedge clk); #1;
    end
    startVec[id] = 1'b0;
    vectorCount++;
    if (ctrlOf(id) !== 4'b0011) begin
      missCount++;
      $display("[TB] FAIL %s done {sel,busy,valid}: got %b want %b", tag, ctrlOf(id), 4'b0011);
    end
    vectorCount++;
    if (sampleOf(id) !== expSample) begin
      missCount++;
      $display("[TB] FAIL %s sample: got %b want %b", tag, sampleOf(id), expSample);
    end
    for (int p = 0; p <= postCycles; p++) begin
      @(posedge clk); #1;
      vectorCount++;
      if ({ctrlOf(id), sampleOf(id)} !== {4'b0000, expSample}) begin
        missCount++;
        $display("[TB] FAIL %s idle p=%0d {sel,busy,valid,sample}: got %b want %b",
                 tag, p, {ctrlOf(id), sampleOf(id)}, {4'b0000, expSample});
      end
    end
  endtask

`ifndef AUTO_RESCAN_EN
  // DWELL=4 with inputs 0,1,0,1: each select is held 4 cycles and the result is 1010.
  task automatic test_basic_scan();
    run_scan(0, 4, 4'b1010, 4'b1010, 4'b0000, -1, 4, "basic");
  endtask

  // A start pulse during SCAN cycle 5 must not queue a second scan.
  task automatic test_ignored_start();
    run_scan(0, 4, 4'b0011, 4'b0011, 4'b1010, 5, 12, "ignored_start");
  endtask

  // Reset on SCAN cycle 9 (channel 2).
  // There must be no valid before the reset, and the next scan must give 1111.
  task automatic test_reset_midscan();
    logic [3:0] want;
    muxIn       = 4'b1010;
    startVec[0] = 1'b1;
    @(posedge clk); #1;
    startVec[0] = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      want = {2'(c / 4), 2'b10};
      vectorCount++;
      if (ctrlOf(0) !== want) begin
        missCount++;
        $display("[TB] FAIL midscan c=%0d {sel,busy,valid}: got %b want %b", c, ctrlOf(0), want);
      end
      if (c != 9) begin
        @(posedge clk); #1;
      end
    end
    #1 rst = 1'b1;
    #1;
    vectorCount++;
    if ({ctrlOf(0), sampleOf(0)} !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL midscan_reset {sel,busy,valid,sample}: got %b want %b", {ctrlOf(0), sampleOf(0)}, 8'h00);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_scan(0, 4, 4'b1111, 4'b1111, 4'b0000, -1, 3, "after_reset");
  endtask

  // DWELL=1: the select changes on every edge, and valid appears after edge k+4.
  task automatic test_dwell1();
    run_scan(1, 1, 4'b1001, 4'b1001, 4'b0000, -1, 3, "dwell1");
  endtask

  // DWELL=2 scan with inputs 0,1,1,0.
  task automatic test_dwell2();
    run_scan(2, 2, 4'b0110, 4'b0110, 4'b0000, -1, 3, "dwell2");
  endtask

  // start held high: a new scan begins on every IDLE visit, giving a 6-cycle period at DWELL=1.
  task automatic test_back_to_back();
    logic [3:0] want;
    int p;
    muxIn       = 4'b0101;
    startVec[1] = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 12; t++) begin
      p = t % 6;
      if (p < 4)       want = {2'(p), 2'b10};
      else if (p == 4) want = 4'b0011;
      else             want = 4'b0000;
      vectorCount++;
      if (ctrlOf(1) !== want) begin
        missCount++;
        $display("[TB] FAIL back_to_back t=%0d {sel,busy,valid}: got %b want %b", t, ctrlOf(1), want);
      end
      if (p == 4) begin
        vectorCount++;
        if (sampleOf(1) !== 4'b0101) begin
          missCount++;
          $display("[TB] FAIL back_to_back sample t=%0d: got %b want %b", t, sampleOf(1), 4'b0101);
        end
      end
      if (t == 11) startVec[1] = 1'b0;
      @(posedge clk); #1;
    end
    vectorCount++;
    if (ctrlOf(1) !== 4'b0000) begin
      missCount++;
      $display("[TB] FAIL back_to_back stop {sel,busy,valid}: got %b want %b", ctrlOf(1), 4'b0000);
    end
  endtask
`else
  // Continuous rescan at DWELL=2.
  // valid must recur every 9 cycles, busy must stay high, and the sample must follow the inputs.
  task automatic test_auto_rescan();
    logic [3:0] insTab [3];
    logic [3:0] want;
    logic [3:0] prev;
    insTab[0]   = 4'b0110;
    insTab[1]   = 4'b1001;
    insTab[2]   = 4'b1111;
    prev        = 4'b0000;
    muxIn       = insTab[0];
    startVec[2] = 1'b1;
    @(posedge clk); #1;
    startVec[2] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 9; c++) begin
        want = (c < 8) ? {2'(c / 2), 2'b10} : 4'b0011;
        vectorCount++;
        if (ctrlOf(2) !== want) begin
          missCount++;
          $display("[TB] FAIL auto s=%0d c=%0d {sel,busy,valid}: got %b want %b", s, c, ctrlOf(2), want);
        end
        vectorCount++;
        if (sampleOf(2) !== ((c < 8) ? prev : insTab[s])) begin
          missCount++;
          $display("[TB] FAIL auto_sample s=%0d c=%0d: got %b want %b", s, c, sampleOf(2),
                   (c < 8) ? prev : insTab[s]);
        end
        if (c == 8) begin
          prev = insTab[s];
          if (s < 2) muxIn = insTab[s + 1];
        end
        @(posedge clk); #1;
      end
    end
  endtask
`endif

  // Watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectorCount = 0;
    missCount   = 0;
    test_reset();
`ifndef AUTO_RESCAN_EN
    test_basic_scan();
    test_ignored_start();
    test_reset_midscan();
    test_dwell1();
    test_dwell2();
    test_back_to_back();
`else
    test_auto_rescan();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
